calcn_mp_core: RTL



---
 rtl/calc_pkg.sv | 35 +++
 rtl/calc_port_queue.sv | 109 ++++++++++
 rtl/calcn_mp_core.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the multi-port calculator core.
//   - command encodings (cmd_e) and response codes (resp_e)
//   - capture FSM state encoding (cap_state_e)
//   - queue entry layout: {cmd[CMD_W], op1[DW], op2[DW]}, MSB first;
//     entry_w() gives its width for a given operand width.
package calc_pkg;

  localparam int CMD_W  = 4;
  localparam int RESP_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_NONE = 2'b00,
    RESP_OK   = 2'b01,
    RESP_OVF  = 2'b10,
    RESP_INV  = 2'b11
  } resp_e;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_OP2  = 1'b1
  } cap_state_e;

  function automatic int entry_w(input int dw);
    return CMD_W + 2 * dw;
  endfunction

endpackage

// File: rtl/calc_port_queue.sv
// calc_port_queue: one requester port of the calculator core.
// Captures a two-cycle request (cmd + op1, then op2), stores it in a
// QDEPTH-entry FIFO and exposes the head entry to the shared arbiter.
// Ports:
//   c_clk      clock, rising edge
//   reset      synchronous active-high reset
//   cmd        command from the requester (ignored while collecting op2)
//   data       operand bus (op1 in the command cycle, op2 the cycle after)
//   pop        arbiter grant: consume the head entry this cycle
//   req_ready  port may start a new command this cycle
//   not_empty  FIFO holds at least one entry
//   head_entry FIFO head, layout {cmd, op1, op2}
module calc_port_queue
  import calc_pkg::*;
#(
  parameter int DW      = 32,
  parameter int QDEPTH  = 4,
  localparam int ENTRY_W = entry_w(DW)
) (
  input  logic               c_clk,
  input  logic               reset,
  input  logic [CMD_W-1:0]   cmd,
  input  logic [DW-1:0]      data,
  input  logic               pop,
  output logic               req_ready,
  output logic               not_empty,
  output logic [ENTRY_W-1:0] head_entry
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  cap_state_e         state_q, state_d;
  logic               capture, push;
  logic               rdy_en;
  logic [CMD_W-1:0]   cmd_q;
  logic [DW-1:0]      op1_q;
  logic [ENTRY_W-1:0] mem [QDEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [OCC_W-1:0]   occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(QDEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Capture FSM: state register
  always_ff @(posedge c_clk) begin
    if (reset) state_q <= CAP_IDLE;
    else       state_q <= state_d;
  end

  // Capture FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      CAP_IDLE: if (capture) state_d = CAP_OP2;
      CAP_OP2:  state_d = CAP_IDLE;
      default:  state_d = CAP_IDLE;
    endcase
  end

  // Capture FSM: outputs
  always_comb begin
    capture = 1'b0;
    push    = 1'b0;
    case (state_q)
      CAP_IDLE: capture = req_ready && (cmd != CMD_NOP);
      CAP_OP2:  push    = 1'b1;
      default:  ;
    endcase
  end

  // A request being collected already owns a slot, so it counts toward
  // occupancy. rdy_en holds ready low for the first cycle out of reset.
  assign occupancy = {1'b0, count} + OCC_W'(state_q == CAP_OP2);
  assign req_ready = rdy_en && (state_q == CAP_IDLE) &&
                     (occupancy < OCC_W'(QDEPTH));
  assign not_empty  = (count != '0);
  assign head_entry = mem[rd_ptr];

  always_ff @(posedge c_clk) begin
    if (reset) begin
      rdy_en <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge c_clk) begin
    if (capture) begin
      cmd_q <= cmd;
      op1_q <= data;
    end
    if (push) mem[wr_ptr] <= {cmd_q, op1_q, data};
  end

endmodule

// File: rtl/calcn_mp_core.sv
// calcn_mp_core: parametrised multi-port calculator core.
// Each port owns a request queue (calc_port_queue); one non-empty queue is
// granted per cycle onto the shared ALU and the registered result is
// returned to that port for exactly one cycle.
// Configuration macro: CALC_RR_ARB_EN selects round-robin arbitration;
// when undefined the lowest-indexed non-empty port wins.
// Ports:
//   c_clk        clock, rising edge
//   reset        synchronous active-high reset
//   req_cmd_in   per-port 4-bit command, port p at [4p +: 4]
//   req_data_in  per-port operand, port p at [DW*p +: DW]
//   req_ready    per-port: may start a new command this cycle
//   out_resp     per-port 2-bit response code, port p at [2p +: 2]
//   out_data     per-port result, port p at [DW*p +: DW]
module calcn_mp_core
  import calc_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int DW     = 32,
  parameter int QDEPTH = 4
) (
  input  logic                   c_clk,
  input  logic                   reset,
  input  logic [4*NPORTS-1:0]    req_cmd_in,
  input  logic [DW*NPORTS-1:0]   req_data_in,
  output logic [NPORTS-1:0]      req_ready,
  output logic [2*NPORTS-1:0]    out_resp,
  output logic [DW*NPORTS-1:0]   out_data
);

  localparam int ENTRY_W = entry_w(DW);
  localparam int SH_W    = $clog2(DW);
  localparam int PORT_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [DW-1:0]    op1;
    logic [DW-1:0]    op2;
  } entry_t;

  typedef struct packed {
    logic [RESP_W-1:0] resp;
    logic [DW-1:0]     data;
  } alu_res_t;

  logic [NPORTS-1:0]  q_not_empty;
  logic [NPORTS-1:0]  q_pop;
  logic [ENTRY_W-1:0] q_head [NPORTS];

  logic               grant_vld_p0;
  logic [PORT_W-1:0]  grant_idx_p0;
  entry_t             head_p0;

  logic               vld_p1;
  logic [PORT_W-1:0]  port_p1;
  alu_res_t           res_p1;

  // Unsigned arithmetic; any overflow/underflow returns data 0. Shifts use
  // only the low log2(DW) bits of op2 as the amount.
  function automatic alu_res_t alu_eval(input logic [CMD_W-1:0] cmd,
                                        input logic [DW-1:0]    op1,
                                        input logic [DW-1:0]    op2);
    logic [DW:0]     sum;
    logic [SH_W-1:0] shamt;
    alu_res_t        res;
    sum      = {1'b0, op1} + {1'b0, op2};
    shamt    = op2[SH_W-1:0];
    res.resp = RESP_INV;
    res.data = '0;
    case (cmd)
      CMD_ADD: begin
        if (sum[DW]) res.resp = RESP_OVF;
        else begin
          res.resp = RESP_OK;
          res.data = sum[DW-1:0];
        end
      end
      CMD_SUB: begin
        if (op1 < op2) res.resp = RESP_OVF;
        else begin
          res.resp = RESP_OK;
          res.data = op1 - op2;
        end
      end
      CMD_SHL: begin
        res.resp = RESP_OK;
        res.data = op1 << shamt;
      end
      CMD_SHR: begin
        res.resp = RESP_OK;
        res.data = op1 >> shamt;
      end
      default: ;
    endcase
    return res;
  endfunction

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    calc_port_queue #(
      .DW     (DW),
      .QDEPTH (QDEPTH)
    ) u_queue (
      .c_clk      (c_clk),
      .reset      (reset),
      .cmd        (req_cmd_in[4*p +: 4]),
      .data       (req_data_in[DW*p +: DW]),
      .pop        (q_pop[p]),
      .req_ready  (req_ready[p]),
      .not_empty  (q_not_empty[p]),
      .head_entry (q_head[p])
    );

    assign q_pop[p] = grant_vld_p0 && (grant_idx_p0 == PORT_W'(p));

    assign out_resp[2*p +: 2]   = (vld_p1 && port_p1 == PORT_W'(p)) ? res_p1.resp : RESP_NONE;
    assign out_data[DW*p +: DW] = (vld_p1 && port_p1 == PORT_W'(p)) ? res_p1.data : '0;
  end

  // Stage p0: arbitration over non-empty queues, head select, ALU
`ifdef CALC_RR_ARB_EN
  logic [PORT_W-1:0] rr_ptr;

  // Scan from rr_ptr upward with wrap; descending k so the closest
  // candidate to rr_ptr is the last (winning) assignment.
  always_comb begin
    int cand;
    cand         = 0;
    grant_vld_p0 = 1'b0;
    grant_idx_p0 = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr) + k) % NPORTS;
      if (q_not_empty[PORT_W'(cand)]) begin
        grant_vld_p0 = 1'b1;
        grant_idx_p0 = PORT_W'(cand);
      end
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) rr_ptr <= '0;
    else if (grant_vld_p0)
      rr_ptr <= (grant_idx_p0 == PORT_W'(NPORTS - 1)) ? '0 : grant_idx_p0 + 1'b1;
  end
`else
  always_comb begin
    grant_vld_p0 = 1'b0;
    grant_idx_p0 = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (q_not_empty[PORT_W'(i)]) begin
        grant_vld_p0 = 1'b1;
        grant_idx_p0 = PORT_W'(i);
      end
    end
  end
`endif

  assign head_p0 = entry_t'(q_head[grant_idx_p0]);

  // Stage p1: registered ALU result, presented to the granted port
  always_ff @(posedge c_clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= grant_vld_p0;
  end

  always_ff @(posedge c_clk) begin
    if (grant_vld_p0) begin
      port_p1 <= grant_idx_p0;
      res_p1  <= alu_eval(head_p0.cmd, head_p0.op1, head_p0.op2);
    end
  end

endmodule
